comp_rr_sched: RTL and testbench

- Shares one bit-serial magnitude comparator among N requesters.
- Uses round-robin arbitration and a request/grant handshake.
- Latches the winning requester's operands and evaluates them MSB-first, one bit per cycle, with optional early termination.
- Returns agtb/altb/aeqb plus the requester ID as a one-cycle done pulse.
- Sits between client blocks and the comparison resource, replacing per-client parallel comparators.

---
 rtl/comp_rr_sched.sv | 162 ++++++++++++++++
 tb/tb_comp_rr_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/comp_rr_sched.sv
// rtl/comp_rr_sched.sv - round-robin shared bit-serial magnitude comparator
// COMP_EARLY_EXIT_EN: stop comparing at the first differing bit instead of walking all SIZE bits.
module comp_rr_sched #(
  parameter int SIZE = 4,
  parameter int N    = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req,
  input  logic [N*SIZE-1:0] a_bus,
  input  logic [N*SIZE-1:0] b_bus,
  output logic [N-1:0]      gnt,
  output logic              busy,
  output logic              done,
  output logic [IDW-1:0]    done_id,
  output logic              agtb,
  output logic              altb,
  output logic              aeqb
);

  localparam int IW = $clog2(SIZE);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nx;

  logic [IDW-1:0]  ptr;
  logic [IW-1:0]   idx;
  logic [SIZE-1:0] a_l;
  logic [SIZE-1:0] b_l;
  logic [IDW-1:0]  id_l;

  logic [IDW-1:0]  win;
  logic            win_found;
  logic [IDW-1:0]  ptr_nx;
  int              slot;

  logic            bit_diff;
  logic            last_bit;
  logic            cmp_end;
  logic            have_diff;
  logic            res_gt;

`ifndef COMP_EARLY_EXIT_EN
  // First differing bit seen so far; later bits must not override it.
  logic            diff_seen;
  logic            diff_gt;
`endif

  // Rotating-priority search: first set request at or above ptr, wrapping.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    slot      = 0;
    for (int k = 0; k < N; k++) begin
      slot = int'(ptr) + k;
      if (slot >= N) slot = slot - N;
      if (!win_found && req[slot]) begin
        win_found = 1'b1;
        win       = IDW'(slot);
      end
    end
  end

  assign ptr_nx   = (win == IDW'(N - 1)) ? '0 : win + 1'b1;
  assign bit_diff = a_l[idx] ^ b_l[idx];
  assign last_bit = (idx == '0);

`ifdef COMP_EARLY_EXIT_EN
  assign cmp_end   = bit_diff | last_bit;
  assign have_diff = bit_diff;
  assign res_gt    = a_l[idx];
`else
  assign cmp_end   = last_bit;
  assign have_diff = diff_seen | bit_diff;
  assign res_gt    = diff_seen ? diff_gt : a_l[idx];
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (win_found) state_nx = CMP;
      CMP:     if (cmp_end) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt     <= '0;
      done    <= 1'b0;
      done_id <= '0;
      agtb    <= 1'b0;
      altb    <= 1'b0;
      aeqb    <= 1'b0;
      ptr     <= '0;
      idx     <= IW'(SIZE - 1);
      a_l     <= '0;
      b_l     <= '0;
      id_l    <= '0;
`ifndef COMP_EARLY_EXIT_EN
      diff_seen <= 1'b0;
      diff_gt   <= 1'b0;
`endif
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            gnt  <= {{(N-1){1'b0}}, 1'b1} << win;
            a_l  <= a_bus[int'(win)*SIZE +: SIZE];
            b_l  <= b_bus[int'(win)*SIZE +: SIZE];
            id_l <= win;
            ptr  <= ptr_nx;
            idx  <= IW'(SIZE - 1);
`ifndef COMP_EARLY_EXIT_EN
            diff_seen <= 1'b0;
            diff_gt   <= 1'b0;
`endif
          end
        end
        CMP: begin
          if (cmp_end) begin
            done    <= 1'b1;
            done_id <= id_l;
            agtb    <= have_diff & res_gt;
            altb    <= have_diff & ~res_gt;
            aeqb    <= ~have_diff;
          end else begin
            idx <= idx - 1'b1;
          end
`ifndef COMP_EARLY_EXIT_EN
          if (!diff_seen && bit_diff) begin
            diff_seen <= 1'b1;
            diff_gt   <= a_l[idx];
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_comp_rr_sched.sv
// tb/tb_comp_rr_sched.sv - self-checking bench for comp_rr_sched
module tb_comp_rr_sched;
  localparam int SIZE = 4;
  localparam int N    = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N*SIZE-1:0] a_bus = '0;
  logic [N*SIZE-1:0] b_bus = '0;
  logic [N-1:0]      gnt;
  logic              busy;
  logic              done;
  logic [IDW-1:0]    done_id;
  logic              agtb;
  logic              altb;
  logic              aeqb;

  comp_rr_sched #(.SIZE(SIZE), .N(N), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .agtb(agtb), .altb(altb), .aeqb(aeqb)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   id;
    logic gt;
    logic lt;
    logic eq;
    int   lat;
  } exp_t;

  typedef struct {
    int              id;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            gt;
    logic            lt;
    logic            eq;
  } vec_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_gnt_cyc = 0;
  int   done_count = 0;
  int   g3_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_lat(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
`ifdef COMP_EARLY_EXIT_EN
    for (int i = SIZE - 1; i >= 0; i--)
      if (a[i] != b[i]) return SIZE - i;
    return SIZE;
`else
    return SIZE;
`endif
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Result monitor: pops the scoreboard whenever done pulses.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (gnt != '0) last_gnt_cyc = cyc;
    if (gnt[3]) g3_count++;
    if (done) begin
      done_count++;
      if (sbq.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sbq.pop_front();
        check("done_id", done_id, e.id);
        check("agtb", agtb, e.gt);
        check("altb", altb, e.lt);
        check("aeqb", aeqb, e.eq);
        check("latency", cyc - last_gnt_cyc, e.lat);
      end
    end
  end

  task automatic push_exp(input int id, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                          input logic gt, input logic lt, input logic eq);
    exp_t e;
    e.id = id; e.gt = gt; e.lt = lt; e.eq = eq; e.lat = model_lat(a, b);
    sbq.push_back(e);
  endtask

  task automatic start_txn(input logic [N-1:0] mask, input int id,
                           input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                           input logic gt, input logic lt, input logic eq);
    int k;
    a_bus = (N*SIZE)'($urandom);
    b_bus = (N*SIZE)'($urandom);
    a_bus[id*SIZE +: SIZE] = a;
    b_bus[id*SIZE +: SIZE] = b;
    req = mask;
    push_exp(id, a, b, gt, lt, eq);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (gnt == '0 && k < 20);
    check("gnt", gnt, 32'(1) << id);
    req   = '0;
    a_bus = (N*SIZE)'($urandom);
    b_bus = (N*SIZE)'($urandom);
  endtask

  task automatic finish_txn();
    int k;
    k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!done) check("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sbq.delete();
  endtask

  vec_t vt[8];

  initial begin
    int k;
    int prev;
    int sp;
    int dc0;
    int g30;

    vt[0] = '{0, 4'b1010, 4'b0110, 1'b1, 1'b0, 1'b0};
    vt[1] = '{2, 4'b0101, 4'b0101, 1'b0, 1'b0, 1'b1};
    vt[2] = '{1, 4'b1000, 4'b0111, 1'b1, 1'b0, 1'b0};
    vt[3] = '{3, 4'b0011, 4'b0100, 1'b0, 1'b1, 1'b0};
    vt[4] = '{0, 4'b1100, 4'b1101, 1'b0, 1'b1, 1'b0};
    vt[5] = '{1, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0};
    vt[6] = '{3, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1};
    vt[7] = '{2, 4'b0110, 4'b0100, 1'b1, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_done_id", done_id, 0);
    check("rst_results", {agtb, altb, aeqb}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      start_txn(N'(1) << vt[i].id, vt[i].id, vt[i].a, vt[i].b, vt[i].gt, vt[i].lt, vt[i].eq);
      finish_txn();
    end
    repeat (3) @(negedge clk);
    check("hold_results", {agtb, altb, aeqb}, 3'b100);

    // Continuous request from everyone: strict rotation, fixed spacing.
    pulse_reset();
    a_bus = {N{4'b1001}};
    b_bus = {N{4'b0001}};
    sp = model_lat(4'b1001, 4'b0001) + 2;
    for (int g = 0; g < 5; g++) push_exp(g % N, 4'b1001, 4'b0001, 1'b1, 1'b0, 1'b0);
    req  = 4'b1111;
    prev = 0;
    for (int g = 0; g < 5; g++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (gnt == '0 && k < 20);
      check("rr_gnt", gnt, 32'(1) << (g % N));
      if (g > 0) check("rr_spacing", cyc - prev, sp);
      prev = cyc;
    end
    req = '0;
    finish_txn();

    // Requester 3 pulses req while busy and then withdraws.
    g30 = g3_count;
    start_txn(4'b0001, 0, 4'b0101, 4'b0101, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    req = 4'b1000;
    @(negedge clk);
    req = 4'b0000;
    finish_txn();
    repeat (4) @(negedge clk);
    check("no_gnt3", g3_count, g30);
    start_txn(4'b1101, 2, 4'b0011, 4'b0100, 1'b0, 1'b1, 1'b0);
    finish_txn();

    // Reset while comparing discards the operation and rewinds ptr.
    start_txn(4'b0010, 1, 4'b0110, 4'b0110, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    void'(sbq.pop_back());
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_results", {agtb, altb, aeqb, 1'b0}, 0);
    check("mid_rst_done_id", done_id, 0);
    dc0 = done_count;
    repeat (6) @(negedge clk);
    check("mid_rst_no_done", done_count, dc0);
    start_txn(4'b1010, 1, 4'b1000, 4'b0001, 1'b1, 1'b0, 1'b0);
    finish_txn();
    start_txn(4'b0100, 2, 4'b0010, 4'b0011, 1'b0, 1'b1, 1'b0);
    finish_txn();

    repeat (3) @(negedge clk);
    check("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
